// File: rtl/counter_date.sv
// -----------------------------------------------------------------------------
// counter_date
//   Day/month BCD calendar counter feeding the year counter. Advances one day
//   per tick_day in run mode, applies month lengths (leap years derived from the
//   year counter's BCD digits) and pulses tick_year on the 12/31 -> 01/01
//   rollover. In manual mode the selected field steps up/down with wrap.
//
//   Optional feature macro: DATE_WEEKDAY_EN (adds weekday, mod-7 counter that
//   advances on every run-mode day advance).
// -----------------------------------------------------------------------------
module counter_date #(
   parameter logic [2:0] WEEKDAY_RST = 3'd0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       mode_date,
   input  logic       sel_month,
   input  logic       up,
   input  logic       down,
   input  logic       tick_day,
   input  logic [3:0] year_unit,
   input  logic [3:0] year_ten,
   input  logic [3:0] year_hundered,
   input  logic [3:0] year_thousand,
   output logic [3:0] day_unit,
   output logic [3:0] day_ten,
   output logic [3:0] month_unit,
   output logic [3:0] month_ten,
   output logic       tick_year
`ifdef DATE_WEEKDAY_EN
   ,
   output logic [2:0] weekday
`endif
);

   function automatic logic f_div4(input logic [3:0] t, input logic [3:0] u);
      if (t[0]) return (u == 4'd2) || (u == 4'd6);
      else      return (u == 4'd0) || (u == 4'd4) || (u == 4'd8);
   endfunction

   function automatic logic [4:0] f_month_len(input logic [3:0] m, input logic leap);
      case (m)
         4'd2:                    return leap ? 5'd29 : 5'd28;
         4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
         default:                 return 5'd31;
      endcase
   endfunction

   function automatic logic [4:0] f_bcd2bin(input logic [3:0] t, input logic [3:0] u);
      return 5'(t) * 5'd10 + 5'(u);
   endfunction

   function automatic logic [7:0] f_bin2bcd(input logic [4:0] b);
      logic [3:0] t;
      logic [4:0] r;
      if (b >= 5'd30)      begin t = 4'd3; r = b - 5'd30; end
      else if (b >= 5'd20) begin t = 4'd2; r = b - 5'd20; end
      else if (b >= 5'd10) begin t = 4'd1; r = b - 5'd10; end
      else                 begin t = 4'd0; r = b;         end
      return {t, 4'(r)};
   endfunction

   logic [3:0] r_day_unit, r_day_ten, r_month_unit, r_month_ten;
   logic       r_tick_year;

   logic       w_yy_zero, w_leap;
   logic [4:0] w_day, w_len;
   logic [3:0] w_month;
   logic [4:0] w_day_nxt;
   logic [3:0] w_month_nxt;
   logic       w_tick_nxt;
   logic       w_day_adv;
   logic [3:0] w_month_sel;
   logic [4:0] w_len_sel;
   logic [7:0] w_day_bcd, w_month_bcd;

   assign w_yy_zero = (year_ten == 4'd0) && (year_unit == 4'd0);
   assign w_leap    = w_yy_zero ? f_div4(year_thousand, year_hundered)
                                : f_div4(year_ten, year_unit);

   assign w_day   = f_bcd2bin(r_day_ten, r_day_unit);
   assign w_month = 4'(f_bcd2bin(r_month_ten, r_month_unit));
   assign w_len   = f_month_len(w_month, w_leap);

   always_comb begin
      w_month_sel = w_month;
      if (up && !down)
         w_month_sel = (w_month == 4'd12) ? 4'd1 : w_month + 4'd1;
      else if (down && !up)
         w_month_sel = (w_month == 4'd1) ? 4'd12 : w_month - 4'd1;
   end
   assign w_len_sel = f_month_len(w_month_sel, w_leap);

   always_comb begin
      w_day_nxt   = w_day;
      w_month_nxt = w_month;
      w_tick_nxt  = 1'b0;
      w_day_adv   = 1'b0;
      if (w_day > w_len) begin
         w_day_nxt = w_len;
      end else if (mode_date) begin
         if (tick_day) begin
            w_day_adv = 1'b1;
            if (w_day == w_len) begin
               w_day_nxt = 5'd1;
               if (w_month == 4'd12) begin
                  w_month_nxt = 4'd1;
                  w_tick_nxt  = 1'b1;
               end else begin
                  w_month_nxt = w_month + 4'd1;
               end
            end else begin
               w_day_nxt = w_day + 5'd1;
            end
         end
      end else if (up ^ down) begin
         if (sel_month) begin
            w_month_nxt = w_month_sel;
            if (w_day > w_len_sel) w_day_nxt = w_len_sel;
         end else if (up) begin
            w_day_nxt = (w_day >= w_len) ? 5'd1 : w_day + 5'd1;
         end else begin
            w_day_nxt = (w_day <= 5'd1) ? w_len : w_day - 5'd1;
         end
      end
   end

   assign w_day_bcd   = f_bin2bcd(w_day_nxt);
   assign w_month_bcd = f_bin2bcd({1'b0, w_month_nxt});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_day_ten    <= 4'd0;
         r_day_unit   <= 4'd1;
         r_month_ten  <= 4'd0;
         r_month_unit <= 4'd1;
         r_tick_year  <= 1'b0;
      end else begin
         r_day_ten    <= w_day_bcd[7:4];
         r_day_unit   <= w_day_bcd[3:0];
         r_month_ten  <= w_month_bcd[7:4];
         r_month_unit <= w_month_bcd[3:0];
         r_tick_year  <= w_tick_nxt;
      end
   end

   assign day_ten    = r_day_ten;
   assign day_unit   = r_day_unit;
   assign month_ten  = r_month_ten;
   assign month_unit = r_month_unit;
   assign tick_year  = r_tick_year;

`ifdef DATE_WEEKDAY_EN
   logic [2:0] r_weekday;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_weekday <= WEEKDAY_RST;
      else if (w_day_adv)
         r_weekday <= (r_weekday == 3'd6) ? 3'd0 : r_weekday + 3'd1;
   end

   assign weekday = r_weekday;
`else
   logic w_unused_weekday;
   assign w_unused_weekday = w_day_adv ^ (^WEEKDAY_RST);
`endif

endmodule
